// File: rtl/bias_array.sv
// Per-column bias adder bank with one-cycle registered lanes and a tile-done row counter.
// Optional macro BIAS_ARRAY_SAT_EN: saturate the biased sum instead of wrapping.
module bias_array #(
   parameter int NUM_COLS = 2,
   parameter int DATA_W   = 16,
   parameter int NUM_ROWS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bias_load_en,
   input  logic [((NUM_COLS > 1) ? $clog2(NUM_COLS) : 1)-1:0] bias_load_col,
   input  logic [DATA_W-1:0]            bias_load_data,
   input  logic                         bias_bypass_in,
   input  logic [NUM_COLS-1:0]          bias_valid_in,
   input  logic [NUM_COLS*DATA_W-1:0]   bias_data_in,
   output logic [NUM_COLS-1:0]          bias_valid_out,
   output logic [NUM_COLS*DATA_W-1:0]   bias_data_out,
   output logic                         bias_done_out
);

   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int CNT_W = $clog2(NUM_ROWS + 1);

   logic [DATA_W-1:0]          bias_bank [NUM_COLS];
   logic [NUM_COLS*DATA_W-1:0] lane_res;
   logic [CNT_W-1:0]           row_cnt;

   // Both operands widened by one bit so the carry into the sign is never lost.
   function automatic logic [DATA_W-1:0] add_bias(input logic [DATA_W-1:0] din,
                                                  input logic [DATA_W-1:0] bias);
      logic [DATA_W:0] sum;
      sum = {din[DATA_W-1], din} + {bias[DATA_W-1], bias};
`ifdef BIAS_ARRAY_SAT_EN
      if (sum[DATA_W] != sum[DATA_W-1]) begin
         return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
      return sum[DATA_W-1:0];
`else
      return sum[DATA_W-1:0];
`endif
   endfunction

   always_comb begin
      lane_res = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (bias_valid_in[c]) begin
            lane_res[c*DATA_W +: DATA_W] = bias_bypass_in
               ? bias_data_in[c*DATA_W +: DATA_W]
               : add_bias(bias_data_in[c*DATA_W +: DATA_W], bias_bank[c]);
         end
      end
   end

   // Bank writes land at the same edge as the lane that reads them, so a
   // colliding sample still sees the old bias.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_COLS; c++) bias_bank[c] <= '0;
         bias_valid_out <= '0;
         bias_data_out  <= '0;
         row_cnt        <= '0;
         bias_done_out  <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_COLS; c++) begin
            if (bias_load_en && (bias_load_col == COL_W'(c))) bias_bank[c] <= bias_load_data;
         end
         bias_valid_out <= bias_valid_in;
         bias_data_out  <= lane_res;
         bias_done_out  <= 1'b0;
         if (bias_valid_in[NUM_COLS-1]) begin
            if (row_cnt == CNT_W'(NUM_ROWS - 1)) begin
               row_cnt       <= '0;
               bias_done_out <= 1'b1;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end
      end
   end

endmodule
